// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, syncs, visible/writable, SOF and vblank pulses, frame count.
// Optional raster interrupt is built only when VIDEO_TIMING_RASTER_IRQ_EN is defined.
module video_timing_gen #(
  parameter int H_ACTIVE  = 320,
  parameter int H_FP      = 8,
  parameter int H_SYNC    = 48,
  parameter int H_BP      = 24,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CW        = 10,
  parameter int FRAME_W   = 8
) (
  input  logic               clk_12_5875,
  input  logic               rst,
  output logic [CW-1:0]      hcounter_o,
  output logic [CW-1:0]      vcounter_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               visible_o,
  output logic               writable_o,
  output logic               sof_o,
  output logic               vblank_start_o,
  output logic [FRAME_W-1:0] frame_count_o,
  input  logic [CW-1:0]      irq_line_i,
  input  logic               irq_en_i,
  input  logic               irq_ack_i,
  output logic               irq_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ON    = HSYNC_POL;
  localparam logic          VS_ON    = VSYNC_POL;

  generate
    if ((H_TOTAL > (1 << CW)) || (V_TOTAL > (1 << CW)) ||
        (H_ACTIVE < 1) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
        (V_ACTIVE < 1) || (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1) ||
        (FRAME_W < 1)) begin : g_param_err
      $error("video_timing_gen: totals exceed 2^CW or a porch/sync width is zero");
    end
  endgenerate

  logic               started_q;
  logic [CW-1:0]      h_q, h_d;
  logic [CW-1:0]      v_q, v_d;
  logic [FRAME_W-1:0] fc_q, fc_d;
  logic               wrap_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               visible_q, visible_d;
  logic               writable_q, writable_d;
  logic               sof_q, sof_d;
  logic               vbs_q, vbs_d;

  // Next-state counters; the first edge after reset loads (0,0) so frame 0 is shown but not announced.
  always_comb begin
    h_d    = h_q;
    v_d    = v_q;
    fc_d   = fc_q;
    wrap_d = 1'b0;
    if (!started_q) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d    = '0;
        fc_d   = fc_q + FRAME_W'(1);
        wrap_d = 1'b1;
      end else begin
        v_d = v_q + CW'(1);
      end
    end else begin
      h_d = h_q + CW'(1);
    end
  end

  // Flags derived from the next-state counters so they line up with the registered counters.
  always_comb begin
    hsync_d    = ((h_d >= HS_START) && (h_d < HS_END)) ? HS_ON : ~HS_ON;
    vsync_d    = ((v_d >= VS_START) && (v_d < VS_END)) ? VS_ON : ~VS_ON;
    visible_d  = (h_d < H_ACT_C) && (v_d < V_ACT_C);
    writable_d = (v_d >= V_ACT_C);
    sof_d      = wrap_d;
    vbs_d      = started_q && (h_d == '0) && (v_d == V_ACT_C);
  end

  // Timing state and registered outputs.
  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) begin
      started_q  <= 1'b0;
      h_q        <= '0;
      v_q        <= '0;
      fc_q       <= '0;
      hsync_q    <= ~HS_ON;
      vsync_q    <= ~VS_ON;
      visible_q  <= 1'b0;
      writable_q <= 1'b1;
      sof_q      <= 1'b0;
      vbs_q      <= 1'b0;
    end else begin
      started_q  <= 1'b1;
      h_q        <= h_d;
      v_q        <= v_d;
      fc_q       <= fc_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      visible_q  <= visible_d;
      writable_q <= writable_d;
      sof_q      <= sof_d;
      vbs_q      <= vbs_d;
    end
  end

  assign hcounter_o     = h_q;
  assign vcounter_o     = v_q;
  assign frame_count_o  = fc_q;
  assign hsync_o        = hsync_q;
  assign vsync_o        = vsync_q;
  assign visible_o      = visible_q;
  assign writable_o     = writable_q;
  assign sof_o          = sof_q;
  assign vblank_start_o = vbs_q;

`ifdef VIDEO_TIMING_RASTER_IRQ_EN
  logic irq_q, irq_d;
  logic irq_set_d;

  // Sticky raster interrupt; a set in the same cycle as an ack takes priority.
  always_comb begin
    irq_set_d = irq_en_i && (h_d == '0) && (v_d == irq_line_i);
    if (irq_set_d) begin
      irq_d = 1'b1;
    end else if (irq_ack_i) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // Raster interrupt register.
  always_ff @(posedge clk_12_5875 or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;
`else
  logic irq_unused;
  assign irq_unused = ^{irq_line_i, irq_en_i, irq_ack_i};
  assign irq_o      = 1'b0;
`endif

`ifdef SIM
  // Frame trace for simulation builds only.
  always_ff @(posedge clk_12_5875) begin
    if (sof_q) begin
      $display("%0t video_timing_gen sof frame_count=%0d", $time, fc_q);
    end
  end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default-geometry instance plus a small-geometry instance checked against an arithmetic raster model.
module tb_video_timing_gen;

  typedef struct packed {
    logic [31:0] h;
    logic [31:0] v;
    logic        hs;
    logic        vs;
    logic        vis;
    logic        wr;
    logic        sof;
    logic        vbs;
    logic        irq;
    logic [31:0] fc;
  } obs_t;

  typedef struct {
    int   t;
    bit   sel;   // 0 = default instance, 1 = small instance
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] d_h, d_v;
  logic       d_hs, d_vs, d_vis, d_wr, d_sof, d_vbs, d_irq;
  logic [7:0] d_fc;
  logic [9:0] d_irq_line = 10'd0;
  logic       d_irq_en   = 1'b0;
  logic       d_irq_ack  = 1'b0;

  logic [4:0] s_h, s_v;
  logic       s_hs, s_vs, s_vis, s_wr, s_sof, s_vbs, s_irq;
  logic [3:0] s_fc;
  logic [4:0] s_irq_line = 5'd0;
  logic       s_irq_en   = 1'b0;
  logic       s_irq_ack  = 1'b0;

  video_timing_gen dut_d (
    .clk_12_5875(clk), .rst(rst),
    .hcounter_o(d_h), .vcounter_o(d_v), .hsync_o(d_hs), .vsync_o(d_vs),
    .visible_o(d_vis), .writable_o(d_wr), .sof_o(d_sof), .vblank_start_o(d_vbs),
    .frame_count_o(d_fc), .irq_line_i(d_irq_line), .irq_en_i(d_irq_en),
    .irq_ack_i(d_irq_ack), .irq_o(d_irq)
  );

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .CW(5), .FRAME_W(4)
  ) dut_s (
    .clk_12_5875(clk), .rst(rst),
    .hcounter_o(s_h), .vcounter_o(s_v), .hsync_o(s_hs), .vsync_o(s_vs),
    .visible_o(s_vis), .writable_o(s_wr), .sof_o(s_sof), .vblank_start_o(s_vbs),
    .frame_count_o(s_fc), .irq_line_i(s_irq_line), .irq_en_i(s_irq_en),
    .irq_ack_i(s_irq_ack), .irq_o(s_irq)
  );

  int total = 0;
  int bad   = 0;
  int t     = -1;   // cycles since the first (0,0) after reset; -1 while in reset
  bit irq_exp = 1'b0;

  // Raster model: position is just cycle count divided by line and frame length.
  function automatic obs_t model(int tt, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb, bit hp, bit vp, int fw);
    obs_t o;
    int ht, vt, h, v;
    o  = '0;
    ht = ha + hf + hsw + hb;
    vt = va + vf + vsw + vb;
    if (tt < 0) begin
      o.hs = ~hp;
      o.vs = ~vp;
      o.wr = 1'b1;
      return o;
    end
    h     = tt % ht;
    v     = (tt / ht) % vt;
    o.h   = 32'(h);
    o.v   = 32'(v);
    o.fc  = 32'((tt / (ht * vt)) % (1 << fw));
    o.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
    o.vs  = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
    o.vis = (h < ha) && (v < va);
    o.wr  = (v >= va);
    o.sof = (h == 0) && (v == 0) && (tt > 0);
    o.vbs = (h == 0) && (v == va);
    return o;
  endfunction

  function automatic obs_t exp_d(int tt);
    return model(tt, 320, 8, 48, 24, 480, 10, 2, 33, 1'b0, 1'b0, 8);
  endfunction

  function automatic obs_t exp_s(int tt);
    return model(tt, 16, 2, 4, 2, 8, 1, 2, 1, 1'b1, 1'b0, 4);
  endfunction

  function automatic obs_t obs_d();
    obs_t o;
    o.h = 32'(d_h); o.v = 32'(d_v); o.hs = d_hs; o.vs = d_vs; o.vis = d_vis;
    o.wr = d_wr; o.sof = d_sof; o.vbs = d_vbs; o.irq = d_irq; o.fc = 32'(d_fc);
    return o;
  endfunction

  function automatic obs_t obs_s();
    obs_t o;
    o.h = 32'(s_h); o.v = 32'(s_v); o.hs = s_hs; o.vs = s_vs; o.vis = s_vis;
    o.wr = s_wr; o.sof = s_sof; o.vbs = s_vbs; o.irq = s_irq; o.fc = 32'(s_fc);
    return o;
  endfunction

  function automatic obs_t mk(int h, int v, bit hs, bit vs, bit vis, bit wr,
                              bit sof, bit vbs, int fc);
    obs_t o;
    o.h = 32'(h); o.v = 32'(v); o.hs = hs; o.vs = vs; o.vis = vis; o.wr = wr;
    o.sof = sof; o.vbs = vbs; o.irq = 1'b0; o.fc = 32'(fc);
    return o;
  endfunction

  task automatic check(string name, obs_t got, obs_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0d got h=%0d v=%0d hs=%b vs=%b vis=%b wr=%b sof=%b vbs=%b irq=%b fc=%0d want h=%0d v=%0d hs=%b vs=%b vis=%b wr=%b sof=%b vbs=%b irq=%b fc=%0d",
               name, t, got.h, got.v, got.hs, got.vs, got.vis, got.wr, got.sof, got.vbs, got.irq, got.fc,
               want.h, want.v, want.hs, want.vs, want.vis, want.wr, want.sof, want.vbs, want.irq, want.fc);
    end
  endtask

  task automatic check_bit(string name, logic got, logic want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0d got=%b want=%b", name, t, got, want);
    end
  endtask

  // One clock: inputs seen at the rising edge, outputs compared at the falling edge.
  task automatic step();
    bit   adv, en_at, ack_at;
    int   line_at;
    obs_t es;
    @(posedge clk);
    adv     = !rst;
    en_at   = s_irq_en;
    ack_at  = s_irq_ack;
    line_at = int'(s_irq_line);
    @(negedge clk);
    if (rst) begin
      t       = -1;
      irq_exp = 1'b0;
    end else if (adv) begin
      t++;
      es = exp_s(t);
`ifdef VIDEO_TIMING_RASTER_IRQ_EN
      irq_exp = (en_at && es.h == 0 && int'(es.v) == line_at) || (irq_exp && !ack_at);
`else
      irq_exp = 1'b0;
`endif
    end else begin
      irq_exp = irq_exp;
    end
    check("dflt_model", obs_d(), exp_d(t));
    es     = exp_s(t);
    es.irq = irq_exp;
    check("small_model", obs_s(), es);
  endtask

  task automatic check_async();
    obs_t es;
    es = exp_s(-1);
    check("async_rst_dflt", obs_d(), exp_d(-1));
    check("async_rst_small", obs_s(), es);
  endtask

  vec_t tbl[24];
  int   idx = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0d got=timeout want=finish", t);
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{0,    1'b0, mk(0,   0,  1, 1, 1, 0, 0, 0, 0)};
    tbl[1]  = '{0,    1'b1, mk(0,   0,  0, 1, 1, 0, 0, 0, 0)};
    tbl[2]  = '{17,   1'b1, mk(17,  0,  0, 1, 0, 0, 0, 0, 0)};
    tbl[3]  = '{18,   1'b1, mk(18,  0,  1, 1, 0, 0, 0, 0, 0)};
    tbl[4]  = '{21,   1'b1, mk(21,  0,  1, 1, 0, 0, 0, 0, 0)};
    tbl[5]  = '{22,   1'b1, mk(22,  0,  0, 1, 0, 0, 0, 0, 0)};
    tbl[6]  = '{23,   1'b1, mk(23,  0,  0, 1, 0, 0, 0, 0, 0)};
    tbl[7]  = '{24,   1'b1, mk(0,   1,  0, 1, 1, 0, 0, 0, 0)};
    tbl[8]  = '{192,  1'b1, mk(0,   8,  0, 1, 0, 1, 0, 1, 0)};
    tbl[9]  = '{216,  1'b1, mk(0,   9,  0, 0, 0, 1, 0, 0, 0)};
    tbl[10] = '{263,  1'b1, mk(23,  10, 0, 0, 0, 1, 0, 0, 0)};
    tbl[11] = '{264,  1'b1, mk(0,   11, 0, 1, 0, 1, 0, 0, 0)};
    tbl[12] = '{287,  1'b1, mk(23,  11, 0, 1, 0, 1, 0, 0, 0)};
    tbl[13] = '{288,  1'b1, mk(0,   0,  0, 1, 1, 0, 1, 0, 1)};
    tbl[14] = '{289,  1'b1, mk(1,   0,  0, 1, 1, 0, 0, 0, 1)};
    tbl[15] = '{319,  1'b0, mk(319, 0,  1, 1, 1, 0, 0, 0, 0)};
    tbl[16] = '{320,  1'b0, mk(320, 0,  1, 1, 0, 0, 0, 0, 0)};
    tbl[17] = '{327,  1'b0, mk(327, 0,  1, 1, 0, 0, 0, 0, 0)};
    tbl[18] = '{328,  1'b0, mk(328, 0,  0, 1, 0, 0, 0, 0, 0)};
    tbl[19] = '{375,  1'b0, mk(375, 0,  0, 1, 0, 0, 0, 0, 0)};
    tbl[20] = '{376,  1'b0, mk(376, 0,  1, 1, 0, 0, 0, 0, 0)};
    tbl[21] = '{399,  1'b0, mk(399, 0,  1, 1, 0, 0, 0, 0, 0)};
    tbl[22] = '{400,  1'b0, mk(0,   1,  1, 1, 1, 0, 0, 0, 0)};
    tbl[23] = '{4608, 1'b1, mk(0,   0,  0, 1, 1, 0, 1, 0, 0)};

    // Reset held for five cycles.
    repeat (5) step();
    rst = 1'b0;

    // Free run over many small frames (frame counter wrap) and several default lines.
    while (t < 5000) begin
      step();
      while (idx < 24 && tbl[idx].t == t) begin
        if (tbl[idx].sel) check($sformatf("tbl_small_%0d", tbl[idx].t), obs_s(), tbl[idx].exp);
        else              check($sformatf("tbl_dflt_%0d", tbl[idx].t), obs_d(), tbl[idx].exp);
        idx++;
      end
    end
    total++;
    if (idx != 24) begin
      bad++;
      $display("FAIL table_reached got=%0d want=24", idx);
    end

    // Asynchronous reset mid-line, then restart from (0,0).
    while ((t % 400) != 150) step();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_async();
    repeat (2) step();
    rst = 1'b0;
    repeat (30) step();

    // Random run lengths and random asynchronous reset pulses.
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(50, 900)) begin
        s_irq_en  = 1'($urandom_range(0, 1));
        s_irq_ack = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 31) == 0) s_irq_line = 5'($urandom_range(0, 15));
        step();
      end
      #($urandom_range(1, 4)) rst = 1'b1;
      #1 check_async();
      repeat ($urandom_range(1, 3)) step();
      #($urandom_range(1, 4)) rst = 1'b0;
      repeat (3) step();
    end

`ifdef VIDEO_TIMING_RASTER_IRQ_EN
    // Raster IRQ on the small instance: rise, set-beats-ack, lone ack, out-of-range line.
    s_irq_en = 1'b1; s_irq_ack = 1'b1; s_irq_line = 5'd5;
    step();
    s_irq_ack = 1'b0;
    for (int n = 0; n < 2; n++) begin
      int guard = 0;
      while (!(exp_s(t + 1).h == 0 && exp_s(t + 1).v == 5) && guard < 400) begin
        step();
        guard++;
      end
      if (guard >= 400) check_bit("irq_wait_timeout", 1'b1, 1'b0);
      if (n == 1) begin
        check_bit("irq_pending_before_set", s_irq, 1'b1);
        s_irq_ack = 1'b1;
      end
      step();
      check_bit(n == 0 ? "irq_rise" : "irq_set_wins", s_irq, 1'b1);
    end
    s_irq_ack = 1'b1;
    step();
    s_irq_ack = 1'b0;
    check_bit("irq_lone_ack_clear", s_irq, 1'b0);
    s_irq_line = 5'd12;
    repeat (300) step();
    check_bit("irq_line_out_of_range", s_irq, 1'b0);
`else
    s_irq_en = 1'b1; s_irq_line = 5'd0;
    repeat (300) step();
    check_bit("irq_tied_low", s_irq, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Parametrised successor to the fixed 320x480 VGA timing generator. It produces horizontal and vertical counters, sync, visible and writable flags from configurable porch and sync widths and polarities. It also adds start-of-frame and vblank-start pulses and a wrapping frame counter. It sits at the front of the GPU pixel pipeline and feeds the PPU fetch logic and the CPU-side VRAM write gate.

Parameters:
H_ACTIVE, 320, visible pixels per line
H_FP, 8, horizontal front porch (pixels)
H_SYNC, 48, hsync width (pixels)
H_BP, 24, horizontal back porch (pixels); H_TOTAL = sum = 400
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = sum = 525
HSYNC_POL, 0, asserted level of hsync_o (0 = active-low)
VSYNC_POL, 0, asserted level of vsync_o
CW, 10, counter width; must satisfy H_TOTAL, V_TOTAL <= 2^CW
FRAME_W, 8, frame counter width

Ports:
clk_12_5875  in  1  pixel clock; all state on rising edge
rst  in  1  reset, asynchronous, active-high
hcounter_o  out  CW  current pixel column, 0..H_TOTAL-1
vcounter_o  out  CW  current line, 0..V_TOTAL-1
hsync_o  out  1  horizontal sync, polarity HSYNC_POL
vsync_o  out  1  vertical sync, polarity VSYNC_POL
visible_o  out  1  high when hcounter_o < H_ACTIVE and vcounter_o < V_ACTIVE
writable_o  out  1  high when vcounter_o >= V_ACTIVE (VRAM safe for CPU)
sof_o  out  1  one-cycle pulse while counters are (0,0)
vblank_start_o  out  1  one-cycle pulse while counters are (0,V_ACTIVE)
frame_count_o  out  FRAME_W  frames completed, wraps
irq_line_i  in  CW  raster IRQ line (feature only)
irq_en_i  in  1  raster IRQ enable (feature only)
irq_ack_i  in  1  clears irq_o (feature only)
irq_o  out  1  sticky raster interrupt (feature only)

Behaviour:
- Reset: the clock is one clk_12_5875; reset is asynchronous and active-high on rst. While rst is high: counters 0, frame_count_o 0, hsync_o = vsync_o = deasserted level, visible_o 0, writable_o 1, sof_o 0, vblank_start_o 0, irq_o 0. Flags are forced regardless of counter state. Reset mid-line or mid-frame takes effect immediately with no pending state.
- hcounter: increments each cycle; at H_TOTAL-1 wraps to 0.
- vcounter: changes only when hcounter == H_TOTAL-1. Increments, or wraps to 0 from V_TOTAL-1.
- frame_count_o increments (mod 2^FRAME_W) on the cycle both counters wrap to 0.
- All flag outputs are registered, computed from next-state counters, so they are aligned with hcounter_o/vcounter_o in the same cycle (zero-cycle skew to counters).
- hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. Default: 328..375.
- vsync asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC for the whole line. Default: 490..491.
- sof_o is low during the first cycle after rst deasserts: frame 0 is not announced. It fires on every subsequent wrap to (0,0).
- Parameter check: elaboration-time assertion that H_TOTAL, V_TOTAL <= 2^CW and every porch/sync value >= 1.
- SIM builds: $display of time and frame_count_o at each sof_o.

Optional Feature:
Macro: VIDEO_TIMING_RASTER_IRQ_EN.
- Defined:
  - irq_o sets on the cycle counters become (0, irq_line_i) while irq_en_i = 1.
  - It stays high until a cycle with irq_ack_i = 1.
  - If set and ack occur in the same cycle, set wins (irq_o stays 1).
  - irq_line_i >= V_TOTAL never fires.
  - Deasserting irq_en_i does not clear a pending irq_o.
- Undefined: irq_* inputs ignored and irq_o tied 0; no raster compare logic is synthesised.

Test Plan:
- Reset: hold rst 5 cycles, release -> counters 0, visible_o 1, writable_o 0, hsync_o = vsync_o = 1, no sof_o on the first cycle.
- Line timing (defaults): run one line -> hsync_o low exactly for h = 328..375. visible_o falls at h = 320. At h = 399 the next cycle gives h = 0 and v = 1.
- Frame wrap: run to (399,524) -> next cycle (0,0) with sof_o = 1 and frame_count_o = 1. Also check vsync_o low for lines 490-491 only, writable_o 1 from line 480, vblank_start_o pulse at (0,480).
- Async reset mid-frame at (150,200) -> outputs return to reset values before the next clock edge. On release, counting restarts from (0,0).
- Non-default params (H 16/2/4/2, V 8/1/2/1, HSYNC_POL = 1) -> hsync_o high for h = 18..21. Line length 24, frame length 12 lines.
- Raster IRQ (feature on): irq_line_i = 100, irq_en_i = 1 -> irq_o rises at (0,100). Ack in the same cycle as the next frame's set keeps irq_o = 1. A lone ack clears it.
